// File: rtl/input_port_fifo_if.sv
// input_port_fifo_if: producer/CPU-side signals of the buffered input port; o_irq exists only with INPUT_PORT_IRQ_EN
interface input_port_fifo_if #(
  parameter int WIDTH_DATA_LENGTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH_DATA_LENGTH-1:0] i_input;
  logic i_write;
  logic i_read;
  logic i_overflow_clr;
  logic [WIDTH_DATA_LENGTH-1:0] o_output;
  logic o_empty;
  logic o_full;
  logic [$clog2(DEPTH):0] o_count;
  logic o_overflow;
`ifdef INPUT_PORT_IRQ_EN
  logic o_irq;
  modport master(output i_input, i_write, i_read, i_overflow_clr,
                 input o_output, o_empty, o_full, o_count, o_overflow, o_irq);
  modport slave(input i_input, i_write, i_read, i_overflow_clr,
                output o_output, o_empty, o_full, o_count, o_overflow, o_irq);
`else
  modport master(output i_input, i_write, i_read, i_overflow_clr,
                 input o_output, o_empty, o_full, o_count, o_overflow);
  modport slave(input i_input, i_write, i_read, i_overflow_clr,
                output o_output, o_empty, o_full, o_count, o_overflow);
`endif
endinterface

// File: rtl/input_port_fifo.sv
// input_port_fifo: DEPTH-entry FIFO ahead of a registered output word with polling flags; INPUT_PORT_IRQ_EN adds a count-threshold Irq
module input_port_fifo #(
  parameter int WIDTH_DATA_LENGTH = 8,
  parameter int DEPTH = 4,
  parameter int IRQ_THRESHOLD = 1
) (
  input logic i_clk,
  input logic i_rst,
  input_port_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH_DATA_LENGTH-1:0] r_mem [DEPTH];
  logic [WIDTH_DATA_LENGTH-1:0] r_output;
  logic [AW-1:0] r_wrpt, r_rdpt;
  logic [CW-1:0] r_count;
  logic r_overflow;
  logic w_empty, w_full, w_acc_r, w_acc_w, w_drop;
  assign w_empty = r_count == '0;
  assign w_full = r_count == CW'(DEPTH);
  assign w_acc_r = bus.i_read & ~w_empty;
  assign w_acc_w = bus.i_write & (~w_full | w_acc_r);
  assign w_drop = bus.i_write & ~w_acc_w;
  assign bus.o_output = r_output;
  assign bus.o_empty = w_empty;
  assign bus.o_full = w_full;
  assign bus.o_count = r_count;
  assign bus.o_overflow = r_overflow;
`ifdef INPUT_PORT_IRQ_EN
  assign bus.o_irq = r_count >= CW'(IRQ_THRESHOLD);
`else
  if (IRQ_THRESHOLD == 0) begin : g_irq_absent
  end
`endif
  // storage array: no reset, contents behind the pointers are don't-care
  always_ff @(posedge i_clk)
    if (w_acc_w) r_mem[r_wrpt] <= bus.i_input;
  // pointers, occupancy and popped word; pointers wrap naturally at DEPTH
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_wrpt <= '0;
      r_rdpt <= '0;
      r_count <= '0;
      r_output <= '0;
    end else begin
      r_wrpt <= w_acc_w ? r_wrpt + AW'(1) : r_wrpt;
      r_rdpt <= w_acc_r ? r_rdpt + AW'(1) : r_rdpt;
      r_count <= r_count + CW'(w_acc_w) - CW'(w_acc_r);
      r_output <= w_acc_r ? r_mem[r_rdpt] : r_output;
    end
  // sticky overflow: a dropped write beats a simultaneous clear
  always_ff @(posedge i_clk)
    if (i_rst) r_overflow <= 1'b0;
    else r_overflow <= w_drop | (r_overflow & ~bus.i_overflow_clr);
endmodule

// File: tb/tb_input_port_fifo.sv
// tb_input_port_fifo: directed checks of ordering, latency, full/empty corner cases, overflow, wrap and optional Irq
module tb_input_port_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  input_port_fifo_if #(.WIDTH_DATA_LENGTH(8), .DEPTH(4)) bus ();
  input_port_fifo #(.WIDTH_DATA_LENGTH(8), .DEPTH(4), .IRQ_THRESHOLD(2)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    bus.i_write = w;
    bus.i_input = d;
    bus.i_read = r;
    bus.i_overflow_clr = c;
    @(posedge clk);
    #1;
    bus.i_write = 1'b0;
    bus.i_read = 1'b0;
    bus.i_overflow_clr = 1'b0;
  endtask
  task automatic irq_check(input string tag, input logic exp);
`ifdef INPUT_PORT_IRQ_EN
    check(tag, 32'(bus.o_irq), 32'(exp));
`endif
  endtask
  initial begin
    bus.i_write = 1'b0;
    bus.i_read = 1'b0;
    bus.i_overflow_clr = 1'b0;
    bus.i_input = '0;
    rst = 1'b1;
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_out", 32'(bus.o_output), 32'h0);
    check("rst_count", 32'(bus.o_count), 0);
    check("rst_empty", 32'(bus.o_empty), 1);
    check("rst_full", 32'(bus.o_full), 0);
    check("rst_ovf", 32'(bus.o_overflow), 0);
    irq_check("rst_irq", 1'b0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    irq_check("irq_c1", 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    irq_check("irq_c2", 1'b1);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    check("ord_count3", 32'(bus.o_count), 3);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("ord_rd1", 32'(bus.o_output), 32'h11);
    irq_check("irq_c2b", 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("ord_rd2", 32'(bus.o_output), 32'h22);
    irq_check("irq_c1b", 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("ord_rd3", 32'(bus.o_output), 32'h33);
    check("ord_empty", 32'(bus.o_empty), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("rd_empty_out", 32'(bus.o_output), 32'h33);
    check("rd_empty_cnt", 32'(bus.o_count), 0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", 32'(bus.o_full), 1);
    check("fill_ovf0", 32'(bus.o_overflow), 0);
    cyc(1'b1, 8'h05, 1'b0, 1'b0);
    check("drop_ovf", 32'(bus.o_overflow), 1);
    check("drop_count", 32'(bus.o_count), 4);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_ovf", 32'(bus.o_output), 32'(i));
    end
    check("drain_empty", 32'(bus.o_empty), 1);
    check("ovf_sticky", 32'(bus.o_overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 32'(bus.o_overflow), 0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    check("simf_out", 32'(bus.o_output), 32'hA1);
    check("simf_count", 32'(bus.o_count), 4);
    check("simf_ovf", 32'(bus.o_overflow), 0);
    for (int i = 2; i <= 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("simf_drain", 32'(bus.o_output), 32'hA0 + 32'(i));
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("simf_last", 32'(bus.o_output), 32'h99);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    check("sime_count", 32'(bus.o_count), 1);
    check("sime_out", 32'(bus.o_output), 32'h99);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("sime_rd", 32'(bus.o_output), 32'h5A);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hC5, 1'b0, 1'b1);
    check("ovf_setwins", 32'(bus.o_overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr2", 32'(bus.o_overflow), 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_c", 32'(bus.o_output), 32'hC0 + 32'(i));
    end
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 8'h41 + 8'(i), 1'b1, 1'b0);
      check("wrap_out", 32'(bus.o_output), 32'h40 + 32'(i));
      check("wrap_count", 32'(bus.o_count), 1);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_last", 32'(bus.o_output), 32'h4C);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    check("mid_count3", 32'(bus.o_count), 3);
    irq_check("irq_c3", 1'b1);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    check("mid_rst_count", 32'(bus.o_count), 0);
    check("mid_rst_empty", 32'(bus.o_empty), 1);
    irq_check("mid_rst_irq", 1'b0);
    cyc(1'b1, 8'hE7, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_rd", 32'(bus.o_output), 32'hE7);
    check("post_rst_empty", 32'(bus.o_empty), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
